dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU datapath (port 0) and an external loader/debug master (port 1). It sits between the requesters and the data memory's address/data/write-enable pins and replaces the direct address-mux drive of that memory. Grants are registered, round-robin in fairness, and capped in burst length so neither master starves the other. Read data is returned one cycle after the access with a valid strobe.

## Interface
- AW, 8, address width (data memory is 2^AW words)
- DW, 8, data width
- MAX_BURST, 4, max consecutive accesses by one owner while the other port is requesting (≥1)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  port request, held while accesses are wanted
- we0 / we1  in  1  1 = write, 0 = read, sampled on granted cycles
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  registered grant, at most one high
- rdata  out  DW  registered read data
- rvalid0 / rvalid1  out  1  rdata valid for that port, one-cycle pulse
- mem_addr  out  AW  to data memory address
- mem_wdata  out  DW  to data memory data_in
- mem_we  out  1  to data memory write_enable
- mem_rdata  in  DW  from data memory data_out (combinational read)

## Operation
- States: IDLE, OWN0, OWN1. gntN = (state == OWNN).
- Access occurs in any cycle with gntN & reqN; mem_addr/mem_wdata driven from owner; mem_we = gntN & reqN & weN & !reset. No owner: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- IDLE: only reqN → OWNN. Both → port not in last_owner. last_owner resets to 1 (port 0 wins first tie).
- OWNN, reqN low → other port if requesting, else IDLE; last_owner ← N.
- OWNN, reqN high: burst counter increments per access. When counter reaches MAX_BURST and the other port requests → switch owner, counter ← 0. If other not requesting, counter saturates at MAX_BURST and ownership continues.
- Owner switch: counter ← 0.
- Read access (we = 0): rdata ← mem_rdata, rvalidN ← 1 next cycle. Writes never assert rvalid. rdata holds its last value when rvalid is low.
- Request with reqN low during a granted cycle: no access, no memory side-effect.

## Timing
- Reset values: state IDLE, gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, rdata = 0, counter 0, last_owner 1. mem_we forced 0 while reset is high.
- Request-to-grant latency: 1 cycle from IDLE. Switch latency: 1 cycle, with no dead cycle between owners.
- Read latency: rvalid one cycle after the granted read cycle. Back-to-back reads give one rvalid per cycle.
- Write commits on the rising edge ending the granted cycle.
- Reset asserted mid-burst: the write in that cycle is suppressed. Pending rvalid is cleared at the edge.
- A requester must keep req/we/addr/wdata stable until it sees its grant. A deassertion before the grant is legal and is treated as no request.

## Configuration
- DMEM_ARB_STATS_EN defined: adds output stall0_cnt (16 bits). It counts cycles with req0 & !gnt0 and saturates at 0xFFFF. It resets to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package: state enum (IDLE/OWN0/OWN1), port index constants PORT_CPU = 0 and PORT_LDR = 1, default AW/DW.
- One sub-module, arb_burst_counter, holds the saturating burst count, clear and limit compare. The FSM, muxing and read-return register stay in dmem_arbiter.

## Test plan
- Reset, then req0 = 1, we0 = 1, addr0 = 0x10, wdata0 = 0xA5. Required: gnt0 = 1 next cycle, mem_we = 1 for one access, and a later port-1 read of 0x10 returns rdata = 0xA5 with rvalid1.
- req0 and req1 both asserted in the same cycle after reset. Required: gnt0 first. Port 0 drops req, then both are asserted again: gnt1 wins.
- MAX_BURST = 4, req0 held with continuous reads and req1 asserted. Required: exactly 4 accesses by port 0, then gnt1 with no idle cycle between.
- req1 read of addr 0x20 (mem holds 0x3C). Required: rvalid1 = 1 and rdata = 0x3C one cycle after the gnt1 access, with rvalid0 = 0.
- reset asserted during a granted write to 0x30 (old value 0x00). Required: 0x30 still reads 0x00, all gnt/rvalid are 0 next cycle, state is IDLE.
- With DMEM_ARB_STATS_EN: port 1 owns for 3 cycles while req0 is high. Required: stall0_cnt increases by 3 (one extra for the request-to-grant cycle if req0 was raised from IDLE).

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DEFAULT_AW        = 8;
    localparam int unsigned DEFAULT_DW        = 8;
    localparam int unsigned DEFAULT_MAX_BURST = 4;

    // Port indices; last_owner holds one of these
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports, read return and data-memory pins of the arbiter.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW = DEFAULT_AW,
    parameter int unsigned DW = DEFAULT_DW
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic [DW-1:0] rdata;
    logic          rvalid0;
    logic          rvalid1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rdata, rvalid0, rvalid1, mem_addr, mem_wdata, mem_we
    );

    // Requester side (CPU datapath and loader)
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rdata, rvalid0, rvalid1
    );

    // Data memory side
    modport mem (
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/arb_burst_counter.sv
// arb_burst_counter: saturating count of accesses by the current owner.
// at_limit_c is high on the access that completes a MAX_BURST run.
module arb_burst_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit_c
);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] count;

    // Count accesses, clear on owner change, hold at MAX_BURST
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CW'(MAX_BURST))) begin
            count <= count + CW'(1);
        end
    end

    assign at_limit_c = (count >= CW'(MAX_BURST - 1));
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin, burst-capped sharing of the single-port data
// memory between the CPU (port 0) and the loader/debug master (port 1).
// Optional: define DMEM_ARB_STATS_EN to add the stall0_cnt output.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW        = DEFAULT_AW,
    parameter int unsigned DW        = DEFAULT_DW,
    parameter int unsigned MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stall0_cnt
`endif
);
    arb_state_e state;
    arb_state_e state_next;
    logic       last_owner;
    logic       access0_c;
    logic       access1_c;
    logic       switch_c;
    logic       at_limit_c;

    assign access0_c = (state == OWN0) && bus.req0;
    assign access1_c = (state == OWN1) && bus.req1;
    assign switch_c  = (state_next != state);

    arb_burst_counter #(.MAX_BURST(MAX_BURST)) u_burst (
        .clk        (clk),
        .reset      (reset),
        .clr        (switch_c),
        .inc        (access0_c || access1_c),
        .at_limit_c (at_limit_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: tie goes to the port that did not own last; hand off on release or burst cap
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_next = (last_owner == PORT_LDR) ? OWN0 : OWN1;
                end else if (bus.req0) begin
                    state_next = OWN0;
                end else if (bus.req1) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    state_next = bus.req1 ? OWN1 : IDLE;
                end else if (at_limit_c && bus.req1) begin
                    state_next = OWN1;
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    state_next = bus.req0 ? OWN0 : IDLE;
                end else if (at_limit_c && bus.req0) begin
                    state_next = OWN0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Remember the most recent owner for the idle tie-break
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= PORT_LDR;
        end else if (state == OWN0) begin
            last_owner <= PORT_CPU;
        end else if (state == OWN1) begin
            last_owner <= PORT_LDR;
        end
    end

    assign bus.gnt0 = (state == OWN0);
    assign bus.gnt1 = (state == OWN1);

    // Memory pin mux from the current owner; write suppressed during reset
    always_comb begin
        bus.mem_addr  = AW'(0);
        bus.mem_wdata = DW'(0);
        bus.mem_we    = 1'b0;
        if (state == OWN0) begin
            bus.mem_addr  = bus.addr0;
            bus.mem_wdata = bus.wdata0;
            bus.mem_we    = bus.req0 && bus.we0 && !reset;
        end else if (state == OWN1) begin
            bus.mem_addr  = bus.addr1;
            bus.mem_wdata = bus.wdata1;
            bus.mem_we    = bus.req1 && bus.we1 && !reset;
        end
    end

    // Read return: capture memory data and pulse the owner's valid one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rdata   <= DW'(0);
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
        end else begin
            bus.rvalid0 <= access0_c && !bus.we0;
            bus.rvalid1 <= access1_c && !bus.we1;
            if ((access0_c && !bus.we0) || (access1_c && !bus.we1)) begin
                bus.rdata <= bus.mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Saturating count of cycles port 0 waits without a grant
    always_ff @(posedge clk) begin
        if (reset) begin
            stall0_cnt <= 16'h0000;
        end else if (bus.req0 && !bus.gnt0 && (stall0_cnt != 16'hFFFF)) begin
            stall0_cnt <= stall0_cnt + 16'h0001;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks with inline checks plus a read-data scoreboard
// fed from a bench-side shadow of the memory contents.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned AW        = 8;
    localparam int unsigned DW        = 8;
    localparam int unsigned MAX_BURST = 4;

    logic clk;
    logic reset;
    logic mem_init;
    int   total;
    int   bad;

    logic [DW-1:0] mem    [256];
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] exp_rd;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall0_cnt;
`endif

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stall0_cnt (stall0_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 32'h20) ? 8'h3C : 8'h00;
        end else if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    // Scoreboard: pop on rvalid, then record this cycle's accesses from the bench's own inputs
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) shadow[i] = (i == 32'h20) ? 8'h3C : 8'h00;
        end else begin
            if (bus.rvalid0 === 1'b1) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL sb_rvalid0_unexpected: got rvalid0=1 want no pending read");
                end else begin
                    exp_rd = q0.pop_front();
                    if (bus.rdata !== exp_rd) begin
                        bad++;
                        $display("FAIL sb_rdata0: got %h want %h", bus.rdata, exp_rd);
                    end
                end
            end
            if (bus.rvalid1 === 1'b1) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL sb_rvalid1_unexpected: got rvalid1=1 want no pending read");
                end else begin
                    exp_rd = q1.pop_front();
                    if (bus.rdata !== exp_rd) begin
                        bad++;
                        $display("FAIL sb_rdata1: got %h want %h", bus.rdata, exp_rd);
                    end
                end
            end
            if (bus.rvalid0 === 1'b1 && bus.rvalid1 === 1'b1) begin
                total++;
                bad++;
                $display("FAIL sb_rvalid_both: got rvalid0=1 rvalid1=1 want at most one");
            end
            if (!reset) begin
                if (bus.gnt0 === 1'b1 && bus.req0) begin
                    if (bus.we0) shadow[bus.addr0] = bus.wdata0;
                    else         q0.push_back(shadow[bus.addr0]);
                end
                if (bus.gnt1 === 1'b1 && bus.req1) begin
                    if (bus.we1) shadow[bus.addr1] = bus.wdata1;
                    else         q1.push_back(shadow[bus.addr1]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_init = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h30; bus.wdata0 = 8'hEE;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
        tick(); tick();
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
            bad++; $display("FAIL rst_gnt: got %b want 00", {bus.gnt0, bus.gnt1});
        end
        total++;
        if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin
            bad++; $display("FAIL rst_rvalid: got %b want 00", {bus.rvalid0, bus.rvalid1});
        end
        total++;
        if (bus.rdata !== 8'h00) begin
            bad++; $display("FAIL rst_rdata: got %h want 00", bus.rdata);
        end
        total++;
        if (bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we);
        end
        reset = 1'b0; mem_init = 1'b0; bus.req0 = 1'b0; bus.we0 = 1'b0;
        tick();
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
            bad++; $display("FAIL rst_idle_gnt: got %b want 00", {bus.gnt0, bus.gnt1});
        end
    endtask

    task automatic test_write_read();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5;
        #1;
        total++;
        if (bus.gnt0 !== 1'b0) begin
            bad++; $display("FAIL wr_gnt_early: got %b want 0", bus.gnt0);
        end
        tick();
        total++;
        if (bus.gnt0 !== 1'b1) begin
            bad++; $display("FAIL wr_gnt0: got %b want 1", bus.gnt0);
        end
        total++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h10, 8'hA5}) begin
            bad++; $display("FAIL wr_mem_pins: got we=%b addr=%h data=%h want we=1 addr=10 data=a5",
                            bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        bus.req0 = 1'b0;
        #1;
        total++;
        if (bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL wr_released_we: got %b want 0", bus.mem_we);
        end
        tick();
        total++;
        if (bus.gnt0 !== 1'b0) begin
            bad++; $display("FAIL wr_release_gnt0: got %b want 0", bus.gnt0);
        end
        bus.we0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h10;
        tick();
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            bad++; $display("FAIL rd_gnt1: got %b want 01", {bus.gnt0, bus.gnt1});
        end
        tick();
        bus.req1 = 1'b0;
        total++;
        if ({bus.rvalid1, bus.rdata} !== {1'b1, 8'hA5}) begin
            bad++; $display("FAIL rd_back_a5: got rvalid1=%b rdata=%h want 1 a5", bus.rvalid1, bus.rdata);
        end
        tick();
    endtask

    task automatic test_tie();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h20;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h10;
        tick();
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            bad++; $display("FAIL tie_first: got %b want 10", {bus.gnt0, bus.gnt1});
        end
        tick();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
            bad++; $display("FAIL tie_idle: got %b want 00", {bus.gnt0, bus.gnt1});
        end
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        tick();
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            bad++; $display("FAIL tie_second: got %b want 01", {bus.gnt0, bus.gnt1});
        end
        tick();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
                bad++; $display("FAIL burst_own0_%0d: got %b want 10", i, {bus.gnt0, bus.gnt1});
            end
            bus.addr0 = (i % 2 == 0) ? 8'h20 : 8'h10;
        end
        tick();
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            bad++; $display("FAIL burst_switch: got %b want 01", {bus.gnt0, bus.gnt1});
        end
        total++;
        if (bus.rvalid0 !== 1'b1) begin
            bad++; $display("FAIL burst_b2b_rvalid0: got %b want 1", bus.rvalid0);
        end
        bus.req0 = 1'b0;
        tick();
        bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        for (int i = 0; i < 9; i++) begin
            tick();
            total++;
            if (bus.gnt0 !== 1'b1) begin
                bad++; $display("FAIL sat_hold_%0d: got gnt0=%b want 1", i, bus.gnt0);
            end
        end
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h40; bus.wdata1 = 8'h5A;
        tick();
        bus.req0 = 1'b0;
        total++;
        if ({bus.gnt0, bus.gnt1, bus.mem_we} !== 3'b011) begin
            bad++; $display("FAIL sat_switch: got gnt=%b%b we=%b want gnt=01 we=1",
                            bus.gnt0, bus.gnt1, bus.mem_we);
        end
        tick();
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        tick();
    endtask

    task automatic test_read_port1();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        tick();
        total++;
        if (bus.gnt1 !== 1'b1) begin
            bad++; $display("FAIL rd1_gnt1: got %b want 1", bus.gnt1);
        end
        tick();
        bus.req1 = 1'b0;
        total++;
        if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== {2'b10, 8'h3C}) begin
            bad++; $display("FAIL rd1_data: got rvalid1=%b rvalid0=%b rdata=%h want 1 0 3c",
                            bus.rvalid1, bus.rvalid0, bus.rdata);
        end
        tick();
        total++;
        if ({bus.rvalid1, bus.rdata} !== {1'b0, 8'h3C}) begin
            bad++; $display("FAIL rd1_hold: got rvalid1=%b rdata=%h want 0 3c", bus.rvalid1, bus.rdata);
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h40;
        tick();
        tick();
        bus.req0 = 1'b0;
        total++;
        if ({bus.rvalid0, bus.rdata} !== {1'b1, 8'h5A}) begin
            bad++; $display("FAIL rd0_loader_write: got rvalid0=%b rdata=%h want 1 5a", bus.rvalid0, bus.rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h30; bus.wdata0 = 8'h77;
        tick();
        total++;
        if (bus.gnt0 !== 1'b1) begin
            bad++; $display("FAIL rstw_gnt0: got %b want 1", bus.gnt0);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL rstw_we_suppressed: got %b want 0", bus.mem_we);
        end
        tick();
        total++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== 4'b0000) begin
            bad++; $display("FAIL rstw_cleared: got %b want 0000",
                            {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1});
        end
        reset = 1'b0; bus.req0 = 1'b0; bus.we0 = 1'b0;
        tick();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h30;
        tick();
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            bad++; $display("FAIL rstw_idle_to_gnt1: got %b want 01", {bus.gnt0, bus.gnt1});
        end
        tick();
        bus.req1 = 1'b0;
        total++;
        if ({bus.rvalid1, bus.rdata} !== {1'b1, 8'h00}) begin
            bad++; $display("FAIL rstw_readback: got rvalid1=%b rdata=%h want 1 00", bus.rvalid1, bus.rdata);
        end
        tick();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        logic [15:0] c0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        tick();
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        c0 = stall0_cnt;
        tick();
        tick();
        tick();
        bus.req1 = 1'b0;
        total++;
        if ({bus.gnt0, stall0_cnt} !== {1'b1, c0 + 16'd3}) begin
            bad++; $display("FAIL stats_stall0: got gnt0=%b cnt=%0d want 1 %0d", bus.gnt0, stall0_cnt, c0 + 16'd3);
        end
        tick();
        bus.req0 = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_tie();
        test_burst();
        test_saturate();
        test_read_port1();
        test_reset_mid_write();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        tick(); tick(); tick();
        total++;
        if ((q0.size() + q1.size()) != 0) begin
            bad++; $display("FAIL sb_drain: got %0d pending reads want 0", q0.size() + q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
